// File: rtl/q_conv_pkg.sv
// Shared types and width constants for the redundant-quotient to binary converter.
package q_conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam int UNROLLING_DEF  = 64;
    localparam int ADDR_WIDTH_DEF = 7;
    localparam int RD_LATENCY_MAX = 3;
    // The WAIT counter only needs to reach RD_LATENCY-1.
    localparam int WAIT_CNT_W     = $clog2(RD_LATENCY_MAX);

endpackage

// File: rtl/q_word_sub.sv
// One word of q_plus - q_minus - borrow_in; the top bit of the widened result is the borrow out.
module q_word_sub
    import q_conv_pkg::*;
#(
    parameter int UNROLLING = UNROLLING_DEF
) (
    input  logic [UNROLLING-1:0] q_plus,
    input  logic [UNROLLING-1:0] q_minus,
    input  logic                 borrow_in,
    output logic [UNROLLING-1:0] diff,
    output logic                 borrow_out
);

    logic [UNROLLING:0] full;

    assign full       = {1'b0, q_plus} - {1'b0, q_minus} - {{UNROLLING{1'b0}}, borrow_in};
    assign diff       = full[UNROLLING-1:0];
    assign borrow_out = full[UNROLLING];

endmodule

// File: rtl/q_word_converter.sv
// Walks the stored q_plus/q_minus words LSW first and streams q_plus - q_minus as binary words.
// Optional result_zero output is enabled by defining Q_CONV_ZERO_DETECT_EN.
module q_word_converter
    import q_conv_pkg::*;
#(
    parameter int UNROLLING  = UNROLLING_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [UNROLLING-1:0]  q_plus_rd,
    input  logic [UNROLLING-1:0]  q_minus_rd,
    output logic [UNROLLING-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done,
`ifdef Q_CONV_ZERO_DETECT_EN
    output logic                  result_zero,
`endif
    output logic                  result_neg
);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH:0]    count;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic                   wait_last;
    logic                   borrow;
    logic [UNROLLING-1:0]   sub_diff;
    logic                   sub_borrow;
`ifdef Q_CONV_ZERO_DETECT_EN
    logic                   zero_acc;
`endif

    q_word_sub #(
        .UNROLLING (UNROLLING)
    ) u_sub (
        .q_plus     (q_plus_rd),
        .q_minus    (q_minus_rd),
        .borrow_in  (borrow),
        .diff       (sub_diff),
        .borrow_out (sub_borrow)
    );

    assign wait_last = (wait_cnt == WAIT_CNT_W'(RD_LATENCY - 1));

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = (num_words == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                rd_en      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = out_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // rd_addr doubles as the word pointer, so it naturally holds between reads.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            count      <= '0;
            wait_cnt   <= '0;
            borrow     <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_index  <= '0;
            result_neg <= 1'b0;
`ifdef Q_CONV_ZERO_DETECT_EN
            zero_acc    <= 1'b0;
            result_zero <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        result_neg <= 1'b0;
                        borrow     <= 1'b0;
                        out_index  <= '0;
                        count      <= num_words;
                        rd_addr    <= base_addr + num_words[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
`ifdef Q_CONV_ZERO_DETECT_EN
                        zero_acc    <= 1'b0;
                        result_zero <= (num_words == '0);
`endif
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    if (wait_last) begin
                        out_data <= sub_diff;
                        borrow   <= sub_borrow;
                        out_last <= (count == (ADDR_WIDTH + 1)'(1));
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            result_neg <= borrow;
`ifdef Q_CONV_ZERO_DETECT_EN
                            result_zero <= ~(zero_acc | (|out_data));
`endif
                        end else begin
                            rd_addr   <= rd_addr - ADDR_WIDTH'(1);
                            out_index <= out_index + ADDR_WIDTH'(1);
                            count     <= count - (ADDR_WIDTH + 1)'(1);
`ifdef Q_CONV_ZERO_DETECT_EN
                            zero_acc  <= zero_acc | (|out_data);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q_word_converter.sv
// Directed bench for q_word_converter with a one-cycle-latency quotient RAM model.
module tb_q_word_converter;

    localparam int UW  = 64;
    localparam int AW  = 7;
    localparam int RDL = 1;

    logic          clk = 1'b0;
    logic          asyn_reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [UW-1:0] q_plus_rd;
    logic [UW-1:0] q_minus_rd;
    logic [UW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [AW-1:0] out_index;
    logic          busy;
    logic          done;
    logic          result_neg;
`ifdef Q_CONV_ZERO_DETECT_EN
    logic          result_zero;
`endif

    q_word_converter #(
        .UNROLLING  (UW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RDL)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .q_plus_rd  (q_plus_rd),
        .q_minus_rd (q_minus_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done),
`ifdef Q_CONV_ZERO_DETECT_EN
        .result_zero(result_zero),
`endif
        .result_neg (result_neg)
    );

    always #5 clk = ~clk;

    logic [UW-1:0] plus_mem  [2**AW];
    logic [UW-1:0] minus_mem [2**AW];

    always @(posedge clk) begin
        if (rd_en) begin
            q_plus_rd  <= plus_mem[rd_addr];
            q_minus_rd <= minus_mem[rd_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [UW-1:0] w_data [8];
    logic [AW-1:0] w_idx  [8];
    logic          w_last [8];
    logic [AW-1:0] rd_log [8];
    int            nw, nrd, done_cyc, first_valid, stall_err;
    logic          neg_at_done, zero_at_done, done_after, busy_after;

    // poke > 0: pulse start at that cycle; poke == -2: raise start during the DONE cycle.
    task automatic convert(input logic [AW-1:0] base, input logic [AW:0] num,
                           input int stall, input int poke);
        int st;
        logic [UW-1:0] held;
        logic have_held;
        nw = 0; nrd = 0; done_cyc = -1; first_valid = -1; stall_err = 0;
        st = 0; have_held = 1'b0; held = '0;
        neg_at_done = 1'bx; zero_at_done = 1'bx;
        base_addr = base; num_words = num; start = 1'b1; out_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
            start = (cyc == poke);
            if (cyc == poke) begin
                base_addr = AW'(50);
                num_words = (AW + 1)'(1);
            end
            if (rd_en) begin
                if (nrd < 8) rd_log[nrd] = rd_addr;
                nrd++;
                if (out_valid) stall_err++;
            end
            if (done) begin
                done_cyc    = cyc;
                neg_at_done = result_neg;
`ifdef Q_CONV_ZERO_DETECT_EN
                zero_at_done = result_zero;
`endif
                if (poke == -2) start = 1'b1;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (have_held && out_data !== held) stall_err++;
                if (st < stall) begin
                    out_ready = 1'b0;
                    st++;
                    held = out_data;
                    have_held = 1'b1;
                end else begin
                    out_ready = 1'b1;
                    if (nw < 8) begin
                        w_data[nw] = out_data;
                        w_idx[nw]  = out_index;
                        w_last[nw] = out_last;
                    end
                    nw++;
                    st = 0;
                    have_held = 1'b0;
                end
            end
            @(negedge clk);
        end
        start      = 1'b0;
        done_after = done;
        busy_after = busy;
        chk("conv_completed", 64'(done_cyc >= 0), 64'(1));
    endtask

    typedef struct {
        logic [UW-1:0] plus;
        logic [UW-1:0] minus;
        logic [UW-1:0] exp_data;
        logic          exp_neg;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{64'h5, 64'h3, 64'h2, 1'b0};
        vecs[1] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[2] = '{64'h1, 64'h0, 64'h1, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{64'h1234, 64'h1234, 64'h0, 1'b0};
        vecs[6] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1};

        asyn_reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; num_words = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(busy),       64'(0));
        chk("rst_rd_en",    64'(rd_en),      64'(0));
        chk("rst_rd_addr",  64'(rd_addr),    64'(0));
        chk("rst_out_data", out_data,        64'(0));
        chk("rst_valid",    64'(out_valid),  64'(0));
        chk("rst_last",     64'(out_last),   64'(0));
        chk("rst_index",    64'(out_index),  64'(0));
        chk("rst_done",     64'(done),       64'(0));
        chk("rst_neg",      64'(result_neg), 64'(0));
`ifdef Q_CONV_ZERO_DETECT_EN
        chk("rst_zero",     64'(result_zero), 64'(0));
`endif
        asyn_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            plus_mem[20 + i]  = vecs[i].plus;
            minus_mem[20 + i] = vecs[i].minus;
            convert(AW'(20 + i), (AW + 1)'(1), 0, 0);
            chk($sformatf("v%0d_words", i), 64'(nw), 64'(1));
            chk($sformatf("v%0d_rdaddr", i), 64'(rd_log[0]), 64'(20 + i));
            chk($sformatf("v%0d_latency", i), 64'(first_valid), 64'(2 + RDL));
            chk($sformatf("v%0d_data", i), w_data[0], vecs[i].exp_data);
            chk($sformatf("v%0d_last", i), 64'(w_last[0]), 64'(1));
            chk($sformatf("v%0d_index", i), 64'(w_idx[0]), 64'(0));
            chk($sformatf("v%0d_neg", i), 64'(neg_at_done), 64'(vecs[i].exp_neg));
            chk($sformatf("v%0d_done_pulse", i), 64'(done_after), 64'(0));
`ifdef Q_CONV_ZERO_DETECT_EN
            chk($sformatf("v%0d_zero", i), 64'(zero_at_done), 64'(vecs[i].exp_data == '0));
`endif
        end

        // Zero length right after a negative result: result_neg must clear.
        convert(AW'(5), '0, 0, 0);
        chk("zl_done_cyc", 64'(done_cyc),    64'(1));
        chk("zl_words",    64'(nw),          64'(0));
        chk("zl_reads",    64'(nrd),         64'(0));
        chk("zl_neg",      64'(neg_at_done), 64'(0));
`ifdef Q_CONV_ZERO_DETECT_EN
        chk("zl_zero",     64'(zero_at_done), 64'(1));
`endif

        plus_mem[11] = 64'h0; minus_mem[11] = 64'h1;
        plus_mem[10] = 64'h1; minus_mem[10] = 64'h0;
        for (int p = 0; p < 3; p++) begin
            convert(AW'(10), (AW + 1)'(2), 0, (p == 0) ? 0 : ((p == 1) ? 2 : -2));
            chk($sformatf("bc%0d_words", p), 64'(nw), 64'(2));
            chk($sformatf("bc%0d_reads", p), 64'(nrd), 64'(2));
            chk($sformatf("bc%0d_rd0", p), 64'(rd_log[0]), 64'(11));
            chk($sformatf("bc%0d_rd1", p), 64'(rd_log[1]), 64'(10));
            chk($sformatf("bc%0d_w0", p), w_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk($sformatf("bc%0d_i0", p), 64'(w_idx[0]), 64'(0));
            chk($sformatf("bc%0d_l0", p), 64'(w_last[0]), 64'(0));
            chk($sformatf("bc%0d_w1", p), w_data[1], 64'h0);
            chk($sformatf("bc%0d_i1", p), 64'(w_idx[1]), 64'(1));
            chk($sformatf("bc%0d_l1", p), 64'(w_last[1]), 64'(1));
            chk($sformatf("bc%0d_neg", p), 64'(neg_at_done), 64'(0));
            chk($sformatf("bc%0d_thruput", p), 64'(done_cyc), 64'(1 + 2 * (2 + RDL)));
            chk($sformatf("bc%0d_idle_after", p), 64'(busy_after), 64'(0));
`ifdef Q_CONV_ZERO_DETECT_EN
            chk($sformatf("bc%0d_zero", p), 64'(zero_at_done), 64'(0));
`endif
        end

        plus_mem[0]   = 64'h7; minus_mem[0]   = 64'h2;
        plus_mem[127] = 64'h3; minus_mem[127] = 64'h3;
        convert(AW'(127), (AW + 1)'(2), 5, 0);
        chk("bp_words",  64'(nw),        64'(2));
        chk("bp_reads",  64'(nrd),       64'(2));
        chk("bp_rd0",    64'(rd_log[0]), 64'(0));
        chk("bp_rd1",    64'(rd_log[1]), 64'(127));
        chk("bp_w0",     w_data[0],      64'h5);
        chk("bp_w1",     w_data[1],      64'h0);
        chk("bp_l1",     64'(w_last[1]), 64'(1));
        chk("bp_stable", 64'(stall_err), 64'(0));
        chk("bp_neg",    64'(neg_at_done), 64'(0));

        plus_mem[30] = 64'h0; minus_mem[30] = 64'h1;
        base_addr = AW'(30); num_words = (AW + 1)'(1); start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("mr_reached_out", 64'(out_valid), 64'(1));
        asyn_reset = 1'b1;
        @(negedge clk);
        asyn_reset = 1'b0;
        chk("mr_busy",     64'(busy),       64'(0));
        chk("mr_valid",    64'(out_valid),  64'(0));
        chk("mr_rd_addr",  64'(rd_addr),    64'(0));
        chk("mr_out_data", out_data,        64'(0));
        chk("mr_last",     64'(out_last),   64'(0));
        chk("mr_neg",      64'(result_neg), 64'(0));
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 4; i++) begin
                if (done) seen_done++;
                @(negedge clk);
            end
            chk("mr_no_done", 64'(seen_done), 64'(0));
        end
        out_ready = 1'b1;
        plus_mem[31] = 64'h9; minus_mem[31] = 64'h4;
        convert(AW'(31), (AW + 1)'(1), 0, 0);
        chk("mr_fresh_data", w_data[0],        64'h5);
        chk("mr_fresh_neg",  64'(neg_at_done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/q_word_converter.md
Name: q_word_converter

Overview:
- Downstream of the quotient-digit register/RAM stage. Reads the stored redundant quotient (q_plus, q_minus word pairs) and converts it to two's-complement binary, q = q_plus - q_minus.
- Walks words from least to most significant and chains the borrow across words.
- Streams each binary word out with a valid/ready handshake and reports the result sign at completion.

Parameters:
- UNROLLING, 64, digits per RAM word (data width).
- ADDR_WIDTH, 7, quotient RAM address width.
- RD_LATENCY, 1, RAM read latency in cycles (1..3).

Ports:
- clk  in  1  clock; all logic on rising edge.
- asyn_reset  in  1  reset; synchronous and active-high, sampled on the clk rising edge.
- start  in  1  conversion request; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  address of the most significant word.
- num_words  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- q_plus_rd  in  UNROLLING  RAM read data, positive digits.
- q_minus_rd  in  UNROLLING  RAM read data, negative digits.
- out_data  out  UNROLLING  binary result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  current word is the most significant.
- out_index  out  ADDR_WIDTH  word index, 0 = least significant.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- result_neg  out  1  final borrow; held until the next accepted start.

Behaviour:
- Reset: state IDLE. rd_en, rd_addr, out_data, out_valid, out_last, out_index, busy, done, result_neg and the borrow register are all 0. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - start & num_words != 0: latch count; set ptr = base_addr + num_words - 1 (mod 2^ADDR_WIDTH); clear borrow and out_index; clear result_neg; go to ISSUE.
  - start & num_words == 0: go to DONE; result_neg = 0; no output words.
- ISSUE: rd_en = 1 and rd_addr = ptr for exactly one cycle; go to WAIT.
- WAIT:
  - Lasts RD_LATENCY cycles.
  - In the final WAIT cycle, compute diff = {0,q_plus_rd} - {0,q_minus_rd} - borrow (width UNROLLING+1).
  - Register out_data = diff[UNROLLING-1:0] and borrow = diff[UNROLLING].
  - Set out_last when the remaining count is 1; go to OUT.
- OUT:
  - out_valid = 1; out_data, out_last and out_index are stable until out_valid & out_ready.
  - On transfer, not last: ptr decrements (wraps 0 -> 2^ADDR_WIDTH-1); out_index increments; count decrements; go to ISSUE.
  - On transfer, last: result_neg = borrow; go to DONE.
  - No RAM read occurs while stalled.
- DONE: done = 1 for one cycle; go to IDLE.
- start is ignored in every state except IDLE, including the DONE cycle.
- Latency: with start sampled at edge T, first out_valid at T + 2 + RD_LATENCY. With out_ready held high, one word per 2 + RD_LATENCY cycles.
- rd_addr holds its last value when rd_en = 0.

Optional Feature:
- Macro: Q_CONV_ZERO_DETECT_EN.
- Enabled:
  - Adds output result_zero (1 bit).
  - Computed as the NOR of all emitted out_data words, accumulated by a sticky OR register cleared on an accepted start.
  - Valid from the DONE cycle; held until the next accepted start; reset value 0.
  - num_words == 0 gives result_zero = 1.
- Disabled: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package q_conv_pkg:
  - State enum (IDLE, ISSUE, WAIT, OUT, DONE).
  - Default width constants UNROLLING_DEF = 64, ADDR_WIDTH_DEF = 7.
  - Width of the WAIT counter, derived from the maximum RD_LATENCY.
- Sub-module q_word_sub: purely combinational UNROLLING-bit subtract with borrow-in/borrow-out, instantiated once.
- FSM, pointer and counters stay in the top module.

Test Plan:
- Single positive word: num_words=1, plus=0x...05, minus=0x...03 -> out_data=0x2, out_last=1, out_index=0, result_neg=0, done pulse.
- Borrow chain across two words:
  - base_addr=10, num_words=2.
  - Address 11: plus=0, minus=1. Address 10: plus=1, minus=0.
  - Expect reads at 11 then 10; outputs 0xFFFF_FFFF_FFFF_FFFF (index 0), then 0x0 (index 1, last); result_neg=0.
- Negative result: num_words=1, plus=0, minus=1 -> out_data=all ones, result_neg=1.
- Backpressure and address wrap:
  - base_addr=127, num_words=2; out_ready low 5 cycles.
  - Expect reads at address 0 then 127.
  - out_data stable and no rd_en while stalled; one transfer per word.
- Zero length and illegal start:
  - num_words=0 -> done 1 cycle after start, no out_valid, result_neg=0.
  - start while busy -> ignored, original sequence completes unchanged.
- Reset mid-operation: assert asyn_reset during OUT -> next cycle IDLE, all outputs 0, no done. A fresh start then converts correctly with borrow cleared.
